instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream fetch stage for the 16-bit processor's Controller.
//  - Owns the program counter; drives the instruction memory read port.
//  - Buffers fetched words with their PC in a small prefetch FIFO.
//  - Hands instructions to the Controller over a valid/ready handshake.
//  - Supports branch/jump redirect (flush) and halt.
// PARAMETERS
//  WIDTH      16  instruction word width
//  I_ADDR_W   7   instruction address width (128-word program space)
//  DEPTH      2   prefetch FIFO entries, power of two, >=2
// PORTS
//  Clk           in   1         processor clock, rising edge
//  Reset         in   1         synchronous, active-low reset
//  imem_rd_en    out  1         instruction memory read strobe
//  imem_addr     out  I_ADDR_W  read address; valid when imem_rd_en=1
//  imem_rdata    in   WIDTH     read data, valid exactly 1 cycle after imem_rd_en
//  ir_valid      out  1         ir_out/ir_pc hold a valid instruction
//  ir_ready      in   1         Controller accepts head instruction this cycle
//  ir_out        out  WIDTH     head instruction word
//  ir_pc         out  I_ADDR_W  address ir_out was fetched from
//  redirect      in   1         load new PC and flush; 1-cycle pulse
//  redirect_pc   in   I_ADDR_W  new fetch address, sampled when redirect=1
//  halt          in   1         stop issuing new fetches; level-sensitive
//  halted        out  1         1 in state HALTED
//  pc_out        out  I_ADDR_W  next address to be fetched (debug)
// BEHAVIOUR
//  Reset (Reset=0 at rising edge):
//   - pc=0, FIFO empty, in-flight flag=0, squash=0, state=RST.
//   - All outputs 0.
//   - Reset wins over every other input, including mid-fetch and mid-redirect.
//  FSM:
//   - RST -> FETCH unconditionally, on the first edge with Reset=1.
//   - FETCH -> HALTED when halt=1 and redirect=0.
//   - HALTED -> FETCH on redirect=1; halt is ignored in that cycle.
//  Issue rule (FETCH only):
//   - imem_rd_en = (occ + inflight - pop) < DEPTH, where pop = ir_valid & ir_ready.
//   - On issue, imem_addr=pc and pc <= pc+1, wrapping 2^I_ADDR_W-1 -> 0.
//  Return:
//   - The cycle after an issue, {imem_rdata, issued pc} is pushed into the FIFO unless squash=1.
//   - The pushed entry is visible on ir_out the following cycle.
//   - Latency from imem_rd_en to ir_valid is 2 cycles; throughput is 1 instr/cycle with ir_ready held at 1.
//  Handshake:
//   - While ir_valid=1 and ir_ready=0, ir_out and ir_pc hold stable.
//   - Simultaneous push and pop leave occ unchanged.
//   - Pop on empty is ignored.
//   - Push when full cannot happen (issue rule); assert this in simulation.
//  Redirect:
//   - Highest priority after reset. Clears the FIFO (occ=0), including an entry popped the same cycle; the Controller owns that pop.
//   - Sets squash if a fetch is in flight, so the returning word is discarded.
//   - pc <= redirect_pc; no issue in the redirect cycle.
//   - The first fetch from redirect_pc occurs the next cycle.
//   - ir_valid=0 the cycle after redirect.
//  Halt:
//   - No new issues. An in-flight word still lands in the FIFO.
//   - The FIFO keeps draining to the Controller.
//   - pc freezes.
//  ir_valid = (occ != 0). ir_out and ir_pc come from registers, with no combinational path from imem_rdata.
// TESTING
//  1. Reset=0 for 2 cycles, then 1, ir_ready=1, imem[k]=16'hA000+k
//     -> rd_en with addr 0 one cycle after release; ir_valid 2 cycles later with ir_out=A000, ir_pc=0; then A001, A002... every cycle.
//  2. ir_ready=0 after fill -> 2 entries held, rd_en=0, ir_out stable;
//     ir_ready=1 -> resumes with no lost or duplicated pc.
//  3. redirect=1, redirect_pc=7'h40, while a fetch is in flight and FIFO is full
//     -> squashed word never appears; next ir_valid carries ir_pc=40, ir_out=A040.
//  4. redirect_pc=7'h7E, free run -> ir_pc sequence 7E, 7F, 00, 01 (wrap).
//  5. halt=1 mid-stream -> halted=1, fetch stops, remaining entries drain;
//     redirect to 7'h10 -> FETCH resumes at 10.
//  6. Reset=0 asserted with redirect=1 and FIFO full -> next cycle all outputs 0, pc_out=0; restart fetches from 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues instruction-memory reads and buffers returned words
// with their PC in a small prefetch FIFO feeding the Controller over valid/ready.
module instr_fetch_unit #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned I_ADDR_W = 7,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  output logic                imem_rd_en,
  output logic [I_ADDR_W-1:0] imem_addr,
  input  logic [WIDTH-1:0]    imem_rdata,
  output logic                ir_valid,
  input  logic                ir_ready,
  output logic [WIDTH-1:0]    ir_out,
  output logic [I_ADDR_W-1:0] ir_pc,
  input  logic                redirect,
  input  logic [I_ADDR_W-1:0] redirect_pc,
  input  logic                halt,
  output logic                halted,
  output logic [I_ADDR_W-1:0] pc_out
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1) + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef enum logic [1:0] {StRst, StFetch, StHalted} state_e;

  state_e state_q, state_d;

  logic [I_ADDR_W-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]    fifo_data_q [DEPTH];
  logic [I_ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     occ_q, occ_d;
  logic                inflight_q, inflight_d;
  logic [I_ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic                squash_q, squash_d;

  logic                pop;
  logic                push;
  logic [CntW-1:0]     pending;
  logic                can_issue;

  assign ir_valid  = (occ_q != '0);
  assign pop       = ir_valid & ir_ready;
  assign pending   = occ_q + CntW'(inflight_q) - CntW'(pop);
  assign can_issue = (pending < Full);

  // The word returning in a redirect cycle belongs to the old stream and is dropped here;
  // squash_q covers a return that lands after the redirect cycle.
  assign push = inflight_q & ~squash_q & ~redirect;

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign ir_out    = ir_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign ir_pc     = ir_valid ? fifo_pc_q[rd_ptr_q]   : '0;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:    state_d = StFetch;
      StFetch:  if (halt && !redirect) state_d = StHalted;
      StHalted: if (redirect) state_d = StFetch;
      default:  state_d = StRst;
    endcase
  end

  // FSM outputs
  always_comb begin
    imem_rd_en = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      StFetch:  imem_rd_en = ~halt & ~redirect & can_issue;
      StHalted: halted = 1'b1;
      default:  ;
    endcase
  end

  // Datapath next state
  always_comb begin
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    occ_d         = occ_q;
    inflight_d    = imem_rd_en;
    inflight_pc_d = inflight_pc_q;
    squash_d      = 1'b0;

    if (redirect) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
      squash_d = inflight_q;
    end else begin
      if (imem_rd_en) begin
        pc_d          = pc_q + I_ADDR_W'(1);
        inflight_pc_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      occ_d = occ_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_q          <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      occ_q         <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      squash_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      occ_q         <= occ_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      squash_q      <= squash_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset && push) begin
      fifo_data_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  push_not_full_a : assert property (@(posedge Clk) disable iff (!Reset) push |-> (occ_q != Full));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, with a scoreboard
// of the PC stream the Controller should receive.
module tb_instr_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        imem_rd_en;
  logic [6:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_out;
  logic [6:0]  ir_pc;
  logic        redirect;
  logic [6:0]  redirect_pc;
  logic        halt;
  logic        halted;
  logic [6:0]  pc_out;

  int errors = 0;
  int checks = 0;
  logic [6:0] sb_q[$];

  instr_fetch_unit dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_out      (ir_out),
    .ir_pc       (ir_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted),
    .pc_out      (pc_out)
  );

  always #5 Clk = ~Clk;

  // Instruction memory: imem[k] = A000 + k, data valid one cycle after the strobe, junk otherwise.
  always @(posedge Clk) begin
    if (imem_rd_en === 1'b1) imem_rdata <= 16'hA000 + {9'd0, imem_addr};
    else                     imem_rdata <= 16'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected instruction stream after a (re)start: consecutive PCs, wrapping at 128.
  function automatic void refill(input logic [6:0] start);
    logic [6:0] p;
    sb_q.delete();
    p = start;
    for (int i = 0; i < 512; i++) begin
      sb_q.push_back(p);
      p = p + 7'd1;
    end
  endfunction

  // Monitor: every accepted instruction must be the next one of the expected stream.
  always @(negedge Clk) begin
    if (ir_valid === 1'b1 && ir_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        logic [6:0] e;
        e = sb_q.pop_front();
        check("acc_pc", {25'd0, ir_pc}, {25'd0, e});
        check("acc_data", {16'd0, ir_out}, 32'h0000A000 + {25'd0, e});
      end
    end
    if (Reset === 1'b0)        refill(7'd0);
    else if (redirect === 1'b1) refill(redirect_pc);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {imem_rd_en, imem_addr, ir_valid, ir_out[6:0], ir_pc, halted, pc_out, 1'b0}
           | {16'd0, ir_out};
  endfunction

  initial begin
    int since;
    int r;
    Reset = 1'b0; ir_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;

    // 1: reset release, latency, streaming
    step(); step();
    Reset = 1'b1; #1;
    check("reset_outs", all_outs(), 32'd0);
    step(); #1;
    check("first_rd_en", {31'd0, imem_rd_en}, 32'd1);
    check("first_addr", {25'd0, imem_addr}, 32'd0);
    step(); #1;
    check("lat_not_yet", {31'd0, ir_valid}, 32'd0);
    step(); #1;
    check("lat_valid", {31'd0, ir_valid}, 32'd1);
    check("lat_pc", {25'd0, ir_pc}, 32'd0);
    check("lat_data", {16'd0, ir_out}, 32'hA000);
    for (int i = 1; i <= 4; i++) begin
      step(); #1;
      check("stream_pc", {25'd0, ir_pc}, i);
    end

    // 2: backpressure holds two entries, no issue, stable head
    step(); ir_ready = 1'b0; #1;
    check("bp_no_issue", {31'd0, imem_rd_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      check("bp_valid", {31'd0, ir_valid}, 32'd1);
      check("bp_rd_en", {31'd0, imem_rd_en}, 32'd0);
      check("bp_pc", {25'd0, ir_pc}, {25'd0, sb_q[0]});
      check("bp_data", {16'd0, ir_out}, 32'h0000A000 + {25'd0, sb_q[0]});
    end
    step(); ir_ready = 1'b1;
    repeat (4) step();

    // 3: redirect with a word in flight and the FIFO filling
    ir_ready = 1'b0; redirect = 1'b1; redirect_pc = 7'h40; #1;
    check("redir_no_issue", {31'd0, imem_rd_en}, 32'd0);
    step(); redirect = 1'b0; #1;
    check("redir_flush", {31'd0, ir_valid}, 32'd0);
    check("redir_addr", {24'd0, imem_rd_en, imem_addr}, 32'hC0);
    step(); ir_ready = 1'b1; #1;
    check("redir_gap", {31'd0, ir_valid}, 32'd0);
    step(); #1;
    check("redir_pc", {24'd0, ir_valid, ir_pc}, 32'hC0);
    check("redir_data", {16'd0, ir_out}, 32'hA040);

    // 4: wrap from 7E
    redirect = 1'b1; redirect_pc = 7'h7E;
    step(); redirect = 1'b0;
    step(); step(); #1;
    check("wrap_7e", {25'd0, ir_pc}, 32'h7E);
    step(); #1; check("wrap_7f", {25'd0, ir_pc}, 32'h7F);
    step(); #1; check("wrap_00", {24'd0, ir_valid, ir_pc}, 32'h80);
    step(); #1; check("wrap_01", {25'd0, ir_pc}, 32'h01);

    // 5: halt, drain, frozen PC, redirect out of HALTED
    step(); halt = 1'b1; #1;
    check("halt_no_issue", {31'd0, imem_rd_en}, 32'd0);
    step(); #1;
    check("halted", {30'd0, halted, imem_rd_en}, 32'd2);
    step(); #1;
    check("halt_drained", {31'd0, ir_valid}, 32'd0);
    check("halt_pc", {25'd0, pc_out}, {25'd0, sb_q[0]});
    step(); #1;
    check("halt_pc_frozen", {25'd0, pc_out}, {25'd0, sb_q[0]});
    redirect = 1'b1; redirect_pc = 7'h10; #1;
    check("halt_redir_no_issue", {31'd0, imem_rd_en}, 32'd0);
    step(); redirect = 1'b0; halt = 1'b0; #1;
    check("resume", {23'd0, halted, imem_rd_en, imem_addr}, 32'h90);
    repeat (5) step();

    // 6: reset beats redirect with a full FIFO
    ir_ready = 1'b0;
    repeat (4) step();
    Reset = 1'b0; redirect = 1'b1; redirect_pc = 7'h33;
    step(); #1;
    check("reset_win", all_outs(), 32'd0);
    Reset = 1'b1; redirect = 1'b0; ir_ready = 1'b1;
    step(); #1;
    check("restart_addr", {24'd0, imem_rd_en, imem_addr}, 32'h80);
    step(); step(); #1;
    check("restart_pc", {24'd0, ir_valid, ir_pc}, 32'h80);

    // Random traffic
    since = 0;
    for (int c = 0; c < 1500; c++) begin
      step();
      Reset = 1'b1;
      redirect = 1'b0;
      ir_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 199);
      since++;
      if (r < 6 || since >= 200) begin
        redirect = 1'b1;
        redirect_pc = 7'($urandom);
        since = 0;
      end else if (r < 10) begin
        halt = ~halt;
      end else if (r == 199) begin
        Reset = 1'b0;
        since = 0;
      end
    end
    step();
    Reset = 1'b1; redirect = 1'b0; halt = 1'b0; ir_ready = 1'b1;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
